fir_stim_source: RTL and testbench

Sample-stream transmitter that drives the 64-tap FIR filter input. It generates a two-tone test signal from two phase-accumulator NCOs and a shared quarter-wave sine table. It presents each sample for SAMPLE_DIV enabled cycles, with a continuous ready enable, so the downstream engine completes one full tap pass per sample. It is used in the filter bench and as an on-chip self-test source.

---
 rtl/fir_stim_source.sv | 182 ++++++++++++++++++
 tb/tb_fir_stim_source.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_stim_source.sv
// Two-tone NCO sample source feeding the 64-tap FIR input; one sample per SAMPLE_DIV run cycles.
// Optional LSB dither from a 16-bit LFSR is enabled by defining STIM_DITHER_EN.
module fir_stim_source #(
    parameter int WIDTH      = 18,
    parameter int PHASE_W    = 16,
    parameter int SAMPLE_DIV = 64,
    parameter int AMP_SHIFT  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     pause,
    input  logic [PHASE_W-1:0]       ftw_a,
    input  logic [PHASE_W-1:0]       ftw_b,
    output logic signed [WIDTH-1:0]  sample_out,
    output logic                     ready,
    output logic                     sample_strobe,
    output logic [15:0]              sample_count
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                do_update;
    logic                do_count;
    logic                do_clear;
    logic [DIV_W-1:0]    div_cnt;
    logic [PHASE_W-1:0]  phase_a;
    logic [PHASE_W-1:0]  phase_b;
    logic signed [15:0]  tone_a;
    logic signed [15:0]  tone_b;
    logic signed [16:0]  tone_sum;
    logic signed [16:0]  wave_shift;
    logic signed [WIDTH-1:0] wave_next;

    // Quarter-wave table: round(32767*sin(2*pi*k/256)), k = 0..64
    function automatic logic [15:0] sine_lut(input logic [6:0] k);
        logic [15:0] v;
        case (k)
            7'd0:  v = 16'd0;     7'd1:  v = 16'd804;   7'd2:  v = 16'd1608;  7'd3:  v = 16'd2410;
            7'd4:  v = 16'd3212;  7'd5:  v = 16'd4011;  7'd6:  v = 16'd4808;  7'd7:  v = 16'd5602;
            7'd8:  v = 16'd6393;  7'd9:  v = 16'd7179;  7'd10: v = 16'd7962;  7'd11: v = 16'd8739;
            7'd12: v = 16'd9512;  7'd13: v = 16'd10278; 7'd14: v = 16'd11039; 7'd15: v = 16'd11793;
            7'd16: v = 16'd12539; 7'd17: v = 16'd13279; 7'd18: v = 16'd14010; 7'd19: v = 16'd14732;
            7'd20: v = 16'd15446; 7'd21: v = 16'd16151; 7'd22: v = 16'd16846; 7'd23: v = 16'd17530;
            7'd24: v = 16'd18204; 7'd25: v = 16'd18868; 7'd26: v = 16'd19519; 7'd27: v = 16'd20159;
            7'd28: v = 16'd20787; 7'd29: v = 16'd21403; 7'd30: v = 16'd22005; 7'd31: v = 16'd22594;
            7'd32: v = 16'd23170; 7'd33: v = 16'd23731; 7'd34: v = 16'd24279; 7'd35: v = 16'd24811;
            7'd36: v = 16'd25329; 7'd37: v = 16'd25832; 7'd38: v = 16'd26319; 7'd39: v = 16'd26790;
            7'd40: v = 16'd27245; 7'd41: v = 16'd27683; 7'd42: v = 16'd28105; 7'd43: v = 16'd28510;
            7'd44: v = 16'd28898; 7'd45: v = 16'd29268; 7'd46: v = 16'd29621; 7'd47: v = 16'd29956;
            7'd48: v = 16'd30273; 7'd49: v = 16'd30571; 7'd50: v = 16'd30852; 7'd51: v = 16'd31113;
            7'd52: v = 16'd31356; 7'd53: v = 16'd31580; 7'd54: v = 16'd31785; 7'd55: v = 16'd31971;
            7'd56: v = 16'd32137; 7'd57: v = 16'd32285; 7'd58: v = 16'd32412; 7'd59: v = 16'd32521;
            7'd60: v = 16'd32609; 7'd61: v = 16'd32678; 7'd62: v = 16'd32728; 7'd63: v = 16'd32757;
            7'd64: v = 16'd32767;
            default: v = 16'd0;
        endcase
        return v;
    endfunction

    // Quadrant 1/3 read the table mirrored, quadrants 2/3 negate.
    function automatic logic signed [15:0] tone(input logic [PHASE_W-1:0] ph);
        logic [7:0]  p;
        logic [6:0]  idx;
        logic [15:0] mag;
        p   = ph[PHASE_W-1 -: 8];
        idx = p[6] ? (7'd64 - {1'b0, p[5:0]}) : {1'b0, p[5:0]};
        mag = sine_lut(idx);
        return p[7] ? -$signed(mag) : $signed(mag);
    endfunction

    assign tone_a = tone(phase_a);
    assign tone_b = tone(phase_b);

`ifdef STIM_DITHER_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign tone_sum = 17'(tone_a) + 17'(tone_b) + $signed({16'd0, lfsr[0]});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else if (do_clear) begin
            lfsr <= 16'hACE1;
        end else if (do_update) begin
            lfsr <= {lfsr[14:0], lfsr_fb};
        end
    end
`else
    assign tone_sum = 17'(tone_a) + 17'(tone_b);
`endif

    assign wave_shift = tone_sum >>> AMP_SHIFT;
    assign wave_next  = WIDTH'(wave_shift);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        do_update = 1'b0;
        do_count  = 1'b0;
        do_clear  = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = RUN;
                    do_update = 1'b1;
                end
            end
            RUN, PAUSE: begin
                if (!enable) begin
                    state_nxt = IDLE;
                    do_clear  = 1'b1;
                end else if (pause) begin
                    state_nxt = PAUSE;
                end else begin
                    // Leaving PAUSE counts on the same edge, so each paused cycle costs one clock.
                    state_nxt = RUN;
                    if (div_cnt == DIV_LAST) begin
                        do_update = 1'b1;
                    end else begin
                        do_count = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign ready = (state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_out    <= '0;
            sample_strobe <= 1'b0;
            sample_count  <= '0;
            phase_a       <= '0;
            phase_b       <= '0;
            div_cnt       <= '0;
        end else if (do_clear) begin
            sample_out    <= '0;
            sample_strobe <= 1'b0;
            sample_count  <= '0;
            phase_a       <= '0;
            phase_b       <= '0;
            div_cnt       <= '0;
        end else begin
            sample_strobe <= do_update;
            if (do_update) begin
                sample_out <= wave_next;
                phase_a    <= phase_a + ftw_a;
                phase_b    <= phase_b + ftw_b;
                div_cnt    <= '0;
                if (sample_count != 16'hFFFF) begin
                    sample_count <= sample_count + 16'd1;
                end
            end else if (do_count) begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_stim_source.sv
// Scoreboard bench for fir_stim_source: expected samples queued at stimulus time, checked on each strobe.
module tb_fir_stim_source;

    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic               pause;
    logic [15:0]        ftw_a;
    logic [15:0]        ftw_b;
    logic signed [17:0] sample_out;
    logic               ready;
    logic               sample_strobe;
    logic [15:0]        sample_count;

    fir_stim_source #(
        .WIDTH(18), .PHASE_W(16), .SAMPLE_DIV(64), .AMP_SHIFT(1)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .pause(pause),
        .ftw_a(ftw_a), .ftw_b(ftw_b),
        .sample_out(sample_out), .ready(ready),
        .sample_strobe(sample_strobe), .sample_count(sample_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int val;
        int cnt;
        int gap;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_strobe = 0;
    int   m_pa, m_pb, m_cnt, m_last;
    int   held;

    task automatic check(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int m_lut(input int k);
        real r;
        r = 32767.0 * $sin(2.0 * 3.14159265358979 * k / 256.0);
        return $rtoi(r + 0.5);
    endfunction

    function automatic int m_tone(input int ph);
        int p, i;
        p = (ph >> 8) & 255;
        i = p & 63;
        case (p >> 6)
            0:       return m_lut(i);
            1:       return m_lut(64 - i);
            2:       return -m_lut(i);
            default: return -m_lut(64 - i);
        endcase
    endfunction

    function automatic int m_wave(input int pa, input int pb);
        return (m_tone(pa) + m_tone(pb)) >>> 1;
    endfunction

    task automatic model_clear();
        m_pa = 0; m_pb = 0; m_cnt = 0; m_last = 0;
    endtask

    // gap = 0: first sample after leaving IDLE, spacing not checked
    task automatic push_sample(input int gap);
        exp_t e;
        e.val = m_wave(m_pa, m_pb);
        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        e.cnt = m_cnt;
        e.gap = gap;
        sb_q.push_back(e);
        m_last = e.val;
        m_pa = (m_pa + int'(ftw_a)) & 16'hFFFF;
        m_pb = (m_pb + int'(ftw_b)) & 16'hFFFF;
    endtask

    task automatic wait_drain(input int budget, input bit chk_ready);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
            if (chk_ready) check("ready_run", ready, 1);
        end
        if (sb_q.size() != 0) begin
            check("drain_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
    endtask

    task automatic restart(input logic [15:0] fa, input logic [15:0] fb);
        @(negedge clk);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        model_clear();
        ftw_a  = fa;
        ftw_b  = fb;
        enable = 1'b1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (sample_strobe === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("strobe_unexpected", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check("sample", $signed(sample_out), mon_e.val);
                check("count", sample_count, mon_e.cnt);
                if (mon_e.gap != 0) check("strobe_gap", cyc - last_strobe, mon_e.gap);
            end
            last_strobe = cyc;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; enable = 1'b0; pause = 1'b0; ftw_a = '0; ftw_b = '0;
        model_clear();
        repeat (10) begin
            @(negedge clk);
            check("rst_sample", $signed(sample_out), 0);
            check("rst_ready", ready, 0);
            check("rst_strobe", sample_strobe, 0);
            check("rst_count", sample_count, 0);
        end
        rst = 1'b0;
        @(negedge clk);

        // single tone at quarter-rate phase steps
        ftw_a = 16'h4000; ftw_b = 16'h0000; enable = 1'b1;
        push_sample(0);
        repeat (4) push_sample(64);
        wait_drain(400, 1'b1);

        restart(16'h4000, 16'h4000);
        push_sample(0);
        repeat (3) push_sample(64);
        wait_drain(400, 1'b1);

        restart(16'hC000, 16'h0000);
        push_sample(0);
        repeat (3) push_sample(64);
        wait_drain(400, 1'b1);

        // pause at div_cnt = 20 for 10 clocks
        restart(16'h4000, 16'h0000);
        push_sample(0);
        push_sample(64);
        wait_drain(200, 1'b1);
        held = m_last;
        push_sample(74);
        push_sample(64);
        repeat (20) @(negedge clk);
        pause = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("pause_ready", ready, 0);
            check("pause_hold", $signed(sample_out), held);
        end
        pause = 1'b0;
        @(negedge clk);
        check("resume_ready", ready, 1);
        wait_drain(200, 1'b0);

        // drop enable mid-interval, re-raise 5 clocks later
        repeat (30) @(negedge clk);
        enable = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("idle_ready", ready, 0);
            check("idle_sample", $signed(sample_out), 0);
            check("idle_count", sample_count, 0);
        end
        model_clear();
        enable = 1'b1;
        push_sample(0);
        push_sample(64);
        wait_drain(200, 1'b1);

        // asynchronous reset while paused
        pause = 1'b1;
        repeat (3) @(negedge clk);
        check("pause_before_rst", $signed(sample_out), m_last);
        #2;
        rst = 1'b1;
        #1;
        check("arst_sample", $signed(sample_out), 0);
        check("arst_ready", ready, 0);
        check("arst_strobe", sample_strobe, 0);
        check("arst_count", sample_count, 0);
        model_clear();
        repeat (2) @(negedge clk);
        pause = 1'b0;
        rst   = 1'b0;
        push_sample(0);
        push_sample(64);
        wait_drain(200, 1'b1);

        repeat (3) @(negedge clk);
        check("queue_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
